// File: rtl/shift_cmd_sequencer.sv
// Command front-end for a 4-bit barrel shifter: breaks shift/rotate commands into
// steps of at most 3 bits, feeding the shifter's result back as the next operand.
module shift_cmd_sequencer #(
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_select,
  input  logic             cmd_direction,
  input  logic [AMT_W-1:0] cmd_amount,
  input  logic [3:0]       cmd_data,
  output logic             bs_select,
  output logic             bs_direction,
  output logic [1:0]       bs_shift_value,
  output logic [3:0]       bs_din,
  input  logic [3:0]       bs_dout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic [AMT_W-1:0] rsp_steps
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             dir_q, dir_d;

  logic [1:0]       step;
  logic [AMT_W-1:0] step_w;
  logic [AMT_W-1:0] eff;

  always_comb begin
    step   = (rem_q > AMT_W'(3)) ? 2'd3 : rem_q[1:0];
    step_w = AMT_W'(step);
    // Rotating a 4-bit word by multiples of 4 is the identity, so only amount mod 4 matters.
    eff    = cmd_select ? AMT_W'(cmd_amount[1:0]) : cmd_amount;
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          work_d  = cmd_data;
          sel_d   = cmd_select;
          dir_d   = cmd_direction;
          cnt_d   = '0;
          rem_d   = eff;
          state_d = (eff == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        work_d = bs_dout;
        rem_d  = rem_q - step_w;
        cnt_d  = cnt_q + AMT_W'(1);
        if (rem_q == step_w) state_d = StDone;
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
    end
  end

  // Outside RUN the shifter sees a zero amount, so its output is a harmless pass-through.
  assign bs_din         = work_q;
  assign bs_select      = sel_q;
  assign bs_direction   = dir_q;
  assign bs_shift_value = (state_q == StRun) ? step : 2'd0;

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign rsp_data  = (state_q == StDone) ? work_q : 4'd0;
  assign rsp_steps = (state_q == StDone) ? cnt_q : '0;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Scoreboard bench for shift_cmd_sequencer with an attached barrel shifter model.
module tb_shift_cmd_sequencer;
  localparam int unsigned AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_select, cmd_direction;
  logic [AMT_W-1:0] cmd_amount;
  logic [3:0]       cmd_data;
  logic             bs_select, bs_direction;
  logic [1:0]       bs_shift_value;
  logic [3:0]       bs_din, bs_dout;
  logic             rsp_valid, rsp_ready;
  logic [3:0]       rsp_data;
  logic [AMT_W-1:0] rsp_steps;

  int n_checks = 0;
  int n_pass   = 0;
  bit rnd_en   = 1'b0;
  bit overlap_seen = 1'b0;
  logic [7:0] sb_q[$];  // {steps, data}

  shift_cmd_sequencer #(.AMT_W(AMT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_select    (cmd_select),
    .cmd_direction (cmd_direction),
    .cmd_amount    (cmd_amount),
    .cmd_data      (cmd_data),
    .bs_select     (bs_select),
    .bs_direction  (bs_direction),
    .bs_shift_value(bs_shift_value),
    .bs_din        (bs_din),
    .bs_dout       (bs_dout),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_steps     (rsp_steps)
  );

  always #5 clk = ~clk;

  // Combinational 4-bit barrel shifter model.
  logic [7:0] bs_tmp;
  always_comb begin
    bs_tmp  = 8'd0;
    bs_dout = 4'd0;
    if (bs_select) begin
      if (bs_direction) begin
        bs_tmp  = {bs_din, bs_din} << bs_shift_value;
        bs_dout = bs_tmp[7:4];
      end else begin
        bs_tmp  = {bs_din, bs_din} >> bs_shift_value;
        bs_dout = bs_tmp[3:0];
      end
    end else begin
      bs_dout = bs_direction ? (bs_din << bs_shift_value) : (bs_din >> bs_shift_value);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: one bit position at a time over the full effective amount.
  function automatic logic [7:0] ref_model(input logic sel, input logic dir,
                                           input logic [AMT_W-1:0] amt, input logic [3:0] d);
    logic [3:0] r;
    int e;
    r = d;
    e = sel ? int'(amt) % 4 : int'(amt);
    for (int i = 0; i < e; i++) begin
      if (sel) r = dir ? {r[2:0], r[3]} : {r[0], r[3:1]};
      else     r = dir ? {r[2:0], 1'b0} : {1'b0, r[3:1]};
    end
    return {4'((e + 2) / 3), r};
  endfunction

  // Monitor: pops expected result on every response handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmd_ready && rsp_valid) overlap_seen = 1'b1;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: got data %0h with empty scoreboard", rsp_data);
        end else begin
          logic [7:0] e;
          e = sb_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e[3:0]));
          chk("rsp_steps", 32'(rsp_steps), 32'(e[7:4]));
        end
      end
    end
  end

  // Random backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called one time unit after a clock edge; returns one time unit after the accept edge.
  task automatic send(input logic sel, input logic dir, input logic [AMT_W-1:0] amt,
                      input logic [3:0] d);
    int n;
    cmd_select = sel; cmd_direction = dir; cmd_amount = amt; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL cmd_accept_timeout: cmd_ready stayed 0");
        $fatal(1);
      end
      @(posedge clk);
    end
    sb_q.push_back(ref_model(sel, dir, amt, d));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_select = 1'($urandom); cmd_direction = 1'($urandom);
    cmd_amount = AMT_W'($urandom); cmd_data = 4'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0 && cmd_ready) break;
      n++;
      if (n > 200) begin
        chk({name, "_drain_timeout"}, 32'd0, 32'd1);
        sb_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Checks response latency (edges after accept) and per-step amounts seen in RUN.
  task automatic lat_cmd(input string name, input logic sel, input logic dir,
                         input logic [AMT_W-1:0] amt, input logic [3:0] d,
                         input int exp_lat, input logic [5:0] exp_steps);
    int n;
    logic [5:0] obs;
    rsp_ready = 1'b0;
    send(sel, dir, amt, d);
    n = 0;
    obs = '0;
    forever begin
      n++;
      @(negedge clk);
      if (rsp_valid) break;
      obs = {obs[3:0], bs_shift_value};
      if (n > 40) break;
      @(posedge clk);
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    chk({name, "_steps_seq"}, 32'(obs), 32'(exp_steps));
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle(name);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({name, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({name, "_rsp_steps"}, 32'(rsp_steps), 32'd0);
    chk({name, "_bs_outs"}, 32'({bs_shift_value, bs_din, bs_select, bs_direction}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_select = 1'b0; cmd_direction = 1'b0;
    cmd_amount = '0; cmd_data = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat_cmd("rotl_1010_5", 1'b1, 1'b1, 4'd5, 4'b1010, 2, 6'b00_00_01);
    lat_cmd("shr_1011_7", 1'b0, 1'b0, 4'd7, 4'b1011, 4, 6'b11_11_01);
    lat_cmd("shl_0001_2", 1'b0, 1'b1, 4'd2, 4'b0001, 2, 6'b00_00_10);
    lat_cmd("rotr_0001_4", 1'b1, 1'b0, 4'd4, 4'b0001, 1, 6'b00_00_00);
    lat_cmd("shl_0110_4", 1'b0, 1'b1, 4'd4, 4'b0110, 3, 6'b00_11_01);
    lat_cmd("rotl_1001_15", 1'b1, 1'b1, 4'd15, 4'b1001, 2, 6'b00_00_11);

    // Backpressure: response held for 5 cycles, then released with a command waiting.
    rsp_ready = 1'b0;
    send(1'b1, 1'b0, 4'd3, 4'b1000);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
    end
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_rsp_data", 32'(rsp_data), 32'b0001);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    cmd_select = 1'b0; cmd_direction = 1'b1; cmd_amount = 4'd1; cmd_data = 4'b0011;
    cmd_valid = 1'b1;
    sb_q.push_back(8'h16);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle("bp_next");

    // Reset in the middle of a long shift.
    send(1'b0, 1'b1, 4'd15, 4'b1111);
    @(posedge clk);
    #1;
    chk("mid_run_bs_step", 32'(bs_shift_value), 32'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_reset");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    send(1'b1, 1'b1, 4'd1, 4'b0011);
    wait_idle("post_reset_rotl");

    // Random commands with random backpressure.
    rnd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(1'($urandom), 1'($urandom), AMT_W'($urandom), 4'($urandom));
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    wait_idle("random");

    chk("ready_valid_overlap", 32'(overlap_seen), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
Sequential command front-end for the 4-bit combinational barrel shifter stage. It accepts shift/rotate commands with amounts up to 15 over a valid/ready interface and breaks each one into steps of at most 3 bits. Each step is driven into the barrel shifter, and the shifter's output is registered back as the next step's operand. The final result is returned on a valid/ready response port, so the block sits directly upstream of the shifter and also consumes what it produces.

Parameters:
AMT_W, 4, width of the command shift amount (maximum amount 2**AMT_W-1); allowed range 2..6.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_select  input  1  0 = shift (zero fill), 1 = rotate
cmd_direction  input  1  0 = right, 1 = left
cmd_amount  input  AMT_W  total bit positions to move
cmd_data  input  4  operand
bs_select  output  1  to barrel shifter select
bs_direction  output  1  to barrel shifter direction
bs_shift_value  output  2  to barrel shifter shift_value (per-step amount)
bs_din  output  4  to barrel shifter din
bs_dout  input  4  from barrel shifter dout (combinational result of bs_* outputs)
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_data  output  4  final shifted/rotated value
rsp_steps  output  AMT_W  number of RUN cycles used for this command

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE; work, remaining, step count, op_sel and op_dir all = 0.
- Outputs during reset: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_steps=0, bs_shift_value=0, bs_din=0, bs_select=0, bs_direction=0.
- States: IDLE, RUN, DONE (registered FSM).
- IDLE: cmd_ready=1, rsp_valid=0.
- Accept: on cmd_valid&&cmd_ready, latch work=cmd_data, op_sel=cmd_select, op_dir=cmd_direction and step count=0.
- Effective amount at accept: eff = cmd_select ? cmd_amount mod 4 : cmd_amount.
  - Rotate reduces modulo 4.
  - Shift uses the full amount; the result saturates to 0000 naturally.
- Next state after accept: eff==0 -> DONE; otherwise -> RUN with remaining=eff.
- RUN: cmd_ready=0. Each cycle:
  - step = min(remaining,3).
  - Drive bs_din=work, bs_shift_value=step, bs_select=op_sel, bs_direction=op_dir.
  - On the clock edge: work<=bs_dout, remaining<=remaining-step, step count+=1.
  - Go to DONE when remaining==step; otherwise stay in RUN.
- Outside RUN: bs_shift_value=0, bs_din=work, bs_select=op_sel, bs_direction=op_dir. This is a pass-through with no side effects.
- DONE: rsp_valid=1, rsp_data=work, rsp_steps=step count, cmd_ready=0. On rsp_ready -> IDLE.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_steps hold stable and no new command is accepted.
- Latency: command accepted at edge T -> rsp_valid high after edge T+1+ceil(eff/3). For eff=0, rsp_valid is high after edge T+1.
- Throughput: one command in flight. cmd_ready and rsp_valid are never high in the same cycle.
- Simultaneity: rsp_ready during DONE returns to IDLE. A command already waiting is accepted no earlier than the following edge.
- Inputs outside handshakes: cmd_* values outside the accept cycle are ignored. rsp_ready outside DONE is ignored.
- Reset mid-operation: rsp_n low in RUN or DONE immediately forces the reset values. The in-flight command is discarded and no response is produced.
- Width rules: remaining is AMT_W bits and never underflows (step ≤ remaining). The step count is AMT_W bits; its maximum is ceil((2**AMT_W-1)/3), which fits.

Test Plan:
- Rotate left, cmd_data=1010, amount=5 -> eff=1, one RUN cycle with bs_shift_value=1 -> rsp_data=0101, rsp_steps=1.
- Shift right, cmd_data=1011, amount=7 -> steps 3,3,1, work 0001, 0000, 0000 -> rsp_data=0000, rsp_steps=3, rsp_valid after edge T+4.
- Shift left, cmd_data=0001, amount=2 -> rsp_data=0100, rsp_steps=1. Rotate right, cmd_data=0001, amount=4 -> eff=0, rsp_data=0001, rsp_steps=0, rsp_valid after edge T+1.
- Backpressure: rotate right, cmd_data=1000, amount=3 -> rsp_data=0001. Hold rsp_ready=0 for 5 cycles -> rsp_data stable, cmd_ready=0 throughout. Release with cmd_valid held high -> next command is accepted the cycle after the response handshake.
- Reset mid-RUN: shift left, cmd_data=1111, amount=15; assert rst_n=0 after the second RUN cycle -> outputs immediately take reset values, no rsp_valid pulse. A subsequent command, rotate left 0011 amount 1 -> rsp_data=0110.
- Randomized cross-check: with a barrel shifter model attached, 1000 random commands with random rsp_ready are compared against a reference shift/rotate model. rsp_steps must equal ceil(eff/3) for every command.
